// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the four request streams and the registered output stage of mux4_rr_arbiter.
// Handshake: a word moves when valid and ready are both high at a rising clock edge.
// The sender holds valid and data steady until that edge, and ready may depend on valid.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [WIDTH-1:0] req_data2;
    logic [WIDTH-1:0] req_data3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    // Requesters and downstream consumer side.
    modport master (
        output req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-input round-robin arbiter. The selected word goes into a one-entry registered output stage.
// dbg_full and dbg_last expose the FSM state and the priority pointer.
module mux4_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_arbiter_if.slave bus,
    output logic             dbg_full,
    output logic [1:0]       dbg_last
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic [1:0]       last;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             found;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

    // Search order is last+1, last+2, last+3, last. The 2-bit add wraps modulo 4.
    always_comb begin
        grant = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && bus.req_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // While reset is held, no grant is offered even though the FSM is EMPTY.
    assign can_accept    = (state == EMPTY) || bus.out_ready;
    assign accept        = rst_n && can_accept && found;
    assign bus.req_ready = accept ? (4'b0001 << grant) : 4'b0000;

    always_comb begin
        case (grant)
            2'd0:    grant_data = bus.req_data0;
            2'd1:    grant_data = bus.req_data1;
            2'd2:    grant_data = bus.req_data2;
            default: grant_data = bus.req_data3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            last         <= 2'd3;
            bus.out_data <= '0;
            bus.out_sel  <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        bus.out_data <= grant_data;
                        bus.out_sel  <= grant;
                        last         <= grant;
                        state        <= FULL;
                    end
                end
                FULL: begin
                    // A new word can replace the old one in the same cycle the old word is consumed.
                    if (accept) begin
                        bus.out_data <= grant_data;
                        bus.out_sel  <= grant;
                        last         <= grant;
                    end else if (bus.out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid = (state == FULL);
    assign dbg_full      = (state == FULL);
    assign dbg_last      = last;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a randomized run.
// Expected values come from a queue-based model of the arbitration rules.
module tb_mux4_rr_arbiter;
    localparam int WIDTH = 8;

    logic       clk;
    logic       rst_n;
    logic       dbg_full;
    logic [1:0] dbg_last;
    logic [WIDTH-1:0] d [4];

    int errors = 0;
    int checks = 0;

    // Model: exp_q holds the word in the output stage (at most one). m_data/m_sel keep the last accepted word.
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH-1:0] m_data;
    logic [1:0]       m_sel;
    int               m_last;

    mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    assign bus.req_data0 = d[0];
    assign bus.req_data1 = d[1];
    assign bus.req_data2 = d[2];
    assign bus.req_data3 = d[3];

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_full (dbg_full),
        .dbg_last (dbg_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        m_data = '0;
        m_sel  = 2'd0;
        m_last = 3;
    endtask

    function automatic int model_grant();
        int idx;
        if (!rst_n) return -1;
        if (exp_q.size() != 0 && !bus.out_ready) return -1;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = model_grant();
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // Advance one clock and apply the same transfer to the model. Returns at posedge+1.
    task automatic clk_step();
        int g;
        g = model_grant();
        @(posedge clk);
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back({2'(g), d[g]});
            m_sel  = 2'(g);
            m_data = d[g];
            m_last = g;
        end
        #1;
    endtask

    task automatic set_inputs(input logic [3:0] v, input logic rdy);
        bus.req_valid = v;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'h11 * WIDTH'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got=%0d want=0", bus.out_sel); end
        checks++;
        if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
        checks++;
        if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b want=0001", bus.req_ready); end
        bus.req_valid = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] tbl [4];
        tbl[0] = 8'hA0; tbl[1] = 8'hB1; tbl[2] = 8'hC2; tbl[3] = 8'hD3;
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = tbl[i];
        for (int c = 0; c < 8; c++) begin
            set_inputs(4'b1111, 1'b1);
            checks++;
            if (bus.req_ready !== model_ready()) begin
                errors++; $display("FAIL rr_req_ready cyc=%0d got=%b want=%b", c, bus.req_ready, model_ready());
            end
            clk_step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(c % 4) || bus.out_data !== tbl[c % 4]) begin
                errors++;
                $display("FAIL rr_output cyc=%0d got=%b/%0d/%h want=1/%0d/%h",
                         c, bus.out_valid, bus.out_sel, bus.out_data, c % 4, tbl[c % 4]);
            end
        end
    endtask

    task automatic test_sparse();
        logic [1:0] seq [4];
        seq[0] = 2'd1; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd3;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_inputs(4'b1010, 1'b1);
            checks++;
            if (bus.req_ready !== model_ready() || bus.req_ready === 4'b0001 || bus.req_ready === 4'b0100) begin
                errors++; $display("FAIL sparse_req_ready cyc=%0d got=%b want=%b", c, bus.req_ready, model_ready());
            end
            clk_step();
            checks++;
            if (bus.out_sel !== seq[c] || bus.out_sel !== m_sel || bus.out_data !== m_data) begin
                errors++; $display("FAIL sparse_grant cyc=%0d got=%0d/%h want=%0d/%h", c, bus.out_sel, bus.out_data, seq[c], m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;
        for (int c = 0; c < 3; c++) begin
            set_inputs(4'b1111, 1'b1);
            clk_step();
        end
        checks++;
        if (bus.out_sel !== 2'd2 || bus.out_data !== 8'hC2 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_setup got=%b/%0d/%h want=1/2/c2", bus.out_valid, bus.out_sel, bus.out_data);
        end
        for (int c = 0; c < 3; c++) begin
            set_inputs(4'b1111, 1'b0);
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0000", c, bus.req_ready);
            end
            clk_step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 8'hC2) begin
                errors++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h want=1/2/c2", c, bus.out_valid, bus.out_sel, bus.out_data);
            end
        end
        set_inputs(4'b1111, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_release_grant got=%b want=1000", bus.req_ready);
        end
        clk_step();
        checks++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 8'hD3) begin
            errors++; $display("FAIL bp_release_out got=%0d/%h want=3/d3", bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_drain_wrap();
        do_reset();
        d[0] = 8'h5A;
        set_inputs(4'b0001, 1'b1);
        clk_step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
            errors++; $display("FAIL drain_accept got=%b/%h want=1/5a", bus.out_valid, bus.out_data);
        end
        set_inputs(4'b0000, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL drain_req_ready got=%b want=0000", bus.req_ready);
        end
        clk_step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h5A || bus.out_sel !== 2'd0) begin
            errors++; $display("FAIL drain_empty got=%b/%0d/%h want=0/0/5a", bus.out_valid, bus.out_sel, bus.out_data);
        end
        d[3] = 8'h33;
        set_inputs(4'b1000, 1'b1);
        clk_step();
        checks++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 8'h33) begin
            errors++; $display("FAIL wrap_lone3 got=%0d/%h want=3/33", bus.out_sel, bus.out_data);
        end
        d[0] = 8'h44;
        set_inputs(4'b0001, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_grant0 got=%b want=0001", bus.req_ready);
        end
        clk_step();
        checks++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 8'h44 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_out0 got=%b/%0d/%h want=1/0/44", bus.out_valid, bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;
        for (int c = 0; c < 2; c++) begin
            set_inputs(4'b1111, 1'b1);
            clk_step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 2'd0) begin
            errors++; $display("FAIL async_reset got=%b/%0d/%h want=0/0/00", bus.out_valid, bus.out_sel, bus.out_data);
        end
        bus.req_valid = 4'b0000;
        #2;
        rst_n = 1'b1;
        clk_step();
        set_inputs(4'b1111, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL async_restart_grant got=%b want=0001", bus.req_ready);
        end
        clk_step();
        checks++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0) begin
            errors++; $display("FAIL async_restart_out got=%0d/%h want=0/a0", bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic [3:0] granted;
        do_reset();
        v       = 4'b0000;
        granted = 4'b0000;
        for (int c = 0; c < 300; c++) begin
            // A requester that was offered ready keeps no word, so it may change. Others keep valid and data.
            for (int i = 0; i < 4; i++) begin
                if (!v[i] || granted[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    d[i] = WIDTH'($urandom);
                end
            end
            set_inputs(v, ($urandom_range(0, 3) != 0));
            granted = model_ready();
            checks++;
            if (bus.req_ready !== granted) begin
                errors++; $display("FAIL rand_req_ready cyc=%0d got=%b want=%b", c, bus.req_ready, granted);
            end
            clk_step();
            checks++;
            if (bus.out_valid !== (exp_q.size() != 0) || bus.out_data !== m_data || bus.out_sel !== m_sel) begin
                errors++;
                $display("FAIL rand_output cyc=%0d got=%b/%0d/%h want=%b/%0d/%h",
                         c, bus.out_valid, bus.out_sel, bus.out_data, (exp_q.size() != 0), m_sel, m_data);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({bus.out_sel, bus.out_data} !== exp_q[0]) begin
                    errors++; $display("FAIL rand_scoreboard cyc=%0d got=%h want=%h", c, {bus.out_sel, bus.out_data}, exp_q[0]);
                end
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_drain_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
